// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
// Optional feature macro: SEQ_MULT_SIGNED_EN adds the is_signed operand qualifier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 is_signed;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result, busy
    );
`else
    // Producer/consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per product,
// valid/ready on both sides. The accumulator shifts right so the adder only spans the
// upper WIDTH+1 bits.
// Optional feature macro: SEQ_MULT_SIGNED_EN (two's complement operands when is_signed=1).
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RES_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept_c;
    logic               last_c;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [RES_W-1:0]   acc_q;
    logic [RES_W-1:0]   acc_c;
    logic [RES_W-1:0]   prod_c;
    logic [RES_W-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;

`ifdef SEQ_MULT_SIGNED_EN
    logic               neg_q;
    logic               neg_c;
`endif

    // Next-state decode plus accept/last-step strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_c = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with registered handshake/status flags derived from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Operand magnitudes and product sign captured at accept
`ifdef SEQ_MULT_SIGNED_EN
    always_comb begin
        a_mag_c = bus.a;
        b_mag_c = bus.b;
        neg_c   = 1'b0;
        if (bus.is_signed) begin
            if (bus.a[WIDTH-1]) a_mag_c = WIDTH'(-bus.a);
            if (bus.b[WIDTH-1]) b_mag_c = WIDTH'(-bus.b);
            neg_c = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag_c = bus.a;
        b_mag_c = bus.b;
    end
`endif

    // One add on the upper slice, then shift the whole accumulator right by one
    always_comb begin
        sum_c = {1'b0, acc_q[RES_W-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_c = {sum_c, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
        prod_c = neg_q ? RES_W'(-acc_c) : acc_c;
`else
        prod_c = acc_c;
`endif
    end

    // Datapath: latch operands on accept, iterate in CALC, load result on the final step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else if (accept_c) begin
            mcand_q  <= a_mag_c;
            mplier_q <= b_mag_c;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q    <= neg_c;
`endif
        end else if (state_q == CALC) begin
            acc_q    <= acc_c;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_c) begin
                result_q <= prod_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: WIDTH=4 main instance plus a WIDTH=8 instance.
module tb_seq_multiplier;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_multiplier_if #(.WIDTH(4)) u_if4 ();
    seq_multiplier_if #(.WIDTH(8)) u_if8 ();

    seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4.slave));
    seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer product, optionally two's complement interpretation
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic sgn);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (sgn) begin
            if (a[3]) sa = sa - 16;
            if (b[3]) sb = sb - 16;
        end
        return 8'(sa * sb);
    endfunction

    // One WIDTH=4 transaction: accept, exact latency, hold under back-pressure, release
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sgn, input int hold);
        logic [7:0] exp;
        int guard;
        exp = ref4(a, b, sgn);
        guard = 0;
        while (u_if4.in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", 64'(u_if4.in_ready), 64'(1'b1));
        u_if4.in_valid = 1'b1;
        u_if4.a = a;
        u_if4.b = b;
`ifdef SEQ_MULT_SIGNED_EN
        u_if4.is_signed = sgn;
`endif
        step();
        u_if4.in_valid = 1'b0;
        u_if4.a = 4'($urandom);
        u_if4.b = 4'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        u_if4.is_signed = 1'($urandom);
`endif
        check("busy_after_accept", 64'(u_if4.busy), 64'(1'b1));
        check("in_ready_after_accept", 64'(u_if4.in_ready), 64'(1'b0));
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) u_if4.in_valid = 1'b1;
            step();
            u_if4.in_valid = 1'b0;
            if (i < 4) begin
                check("no_early_valid", 64'(u_if4.out_valid), 64'(1'b0));
            end else begin
                check("valid_at_latency", 64'(u_if4.out_valid), 64'(1'b1));
                check("product", 64'(u_if4.result), 64'(exp));
            end
        end
        for (int h = 0; h < hold; h++) begin
            u_if4.in_valid = 1'b1;
            u_if4.a = 4'($urandom);
            u_if4.b = 4'($urandom);
            step();
            check("held_valid", 64'(u_if4.out_valid), 64'(1'b1));
            check("held_result", 64'(u_if4.result), 64'(exp));
            check("held_in_ready", 64'(u_if4.in_ready), 64'(1'b0));
        end
        u_if4.in_valid = 1'b0;
        u_if4.out_ready = 1'b1;
        step();
        u_if4.out_ready = 1'b0;
        check("idle_valid", 64'(u_if4.out_valid), 64'(1'b0));
        check("idle_in_ready", 64'(u_if4.in_ready), 64'(1'b1));
        check("idle_busy", 64'(u_if4.busy), 64'(1'b0));
        check("idle_result_kept", 64'(u_if4.result), 64'(exp));
    endtask

    // One WIDTH=8 unsigned transaction with exact latency check
    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp;
        exp = 16'(int'(a) * int'(b));
        check("w8_in_ready", 64'(u_if8.in_ready), 64'(1'b1));
        u_if8.in_valid = 1'b1;
        u_if8.a = a;
        u_if8.b = b;
        step();
        u_if8.in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) check("w8_no_early_valid", 64'(u_if8.out_valid), 64'(1'b0));
        end
        check("w8_valid_at_latency", 64'(u_if8.out_valid), 64'(1'b1));
        check("w8_product", 64'(u_if8.result), 64'(exp));
        u_if8.out_ready = 1'b1;
        step();
        u_if8.out_ready = 1'b0;
        check("w8_idle_valid", 64'(u_if8.out_valid), 64'(1'b0));
    endtask

    initial begin
        int seen_valid;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        u_if4.in_valid = 1'b0;
        u_if4.out_ready = 1'b0;
        u_if4.a = '0;
        u_if4.b = '0;
        u_if8.in_valid = 1'b0;
        u_if8.out_ready = 1'b0;
        u_if8.a = '0;
        u_if8.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
        u_if4.is_signed = 1'b0;
        u_if8.is_signed = 1'b0;
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check("rst_in_ready", 64'(u_if4.in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(u_if4.out_valid), 64'(1'b0));
        check("rst_busy", 64'(u_if4.busy), 64'(1'b0));
        check("rst_result", 64'(u_if4.result), 64'(8'h00));
        check("rst_result_w8", 64'(u_if8.result), 64'(16'h0000));

        run4(4'd15, 4'd15, 1'b0, 0);
        run4(4'd0, 4'd9, 1'b0, 0);
        run4(4'd9, 4'd0, 1'b0, 0);
        run4(4'd6, 4'd7, 1'b0, 5);

        // Reset two cycles after accept abandons the product
        u_if4.in_valid = 1'b1;
        u_if4.a = 4'd5;
        u_if4.b = 4'd5;
        step();
        u_if4.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(u_if4.in_ready), 64'(1'b1));
        check("midrst_out_valid", 64'(u_if4.out_valid), 64'(1'b0));
        check("midrst_busy", 64'(u_if4.busy), 64'(1'b0));
        check("midrst_result", 64'(u_if4.result), 64'(8'h00));
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (u_if4.out_valid !== 1'b0) seen_valid++;
        end
        check("midrst_no_result", 64'(seen_valid), 64'(0));
        run4(4'd3, 4'd3, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            run4(4'($urandom), 4'($urandom), 1'b0, int'($urandom_range(0, 3)));
        end

`ifdef SEQ_MULT_SIGNED_EN
        run4(4'h8, 4'h8, 1'b1, 0);
        run4(4'h8, 4'h7, 1'b1, 1);
        run4(4'hF, 4'h1, 1'b1, 0);
        for (int n = 0; n < 12; n++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
`endif

        run8(8'd255, 8'd255);
        for (int n = 0; n < 4; n++) begin
            run8(8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
